// File: rtl/led_pattern_pkg.sv
// -----------------------------------------------------------------------------
// led_pattern_pkg
// Shared definitions for the LED pattern generator and its receive-side
// monitor: mode encodings, bus width, LFSR tap mask and the single-step
// update function for every pattern mode.
// Ports: none (package).
// -----------------------------------------------------------------------------
package led_pattern_pkg;

  localparam int PATTERN_W = 8;
  localparam int NUM_MODES = 4;

  typedef enum logic [1:0] {
    MODE_BINARY  = 2'd0,
    MODE_SCANNER = 2'd1,
    MODE_LFSR    = 2'd2,
    MODE_ALT     = 2'd3
  } mode_e;

  // Feedback taps on bits 7, 5, 4 and 3.
  localparam logic [PATTERN_W-1:0] LFSR_TAPS = 8'b1011_1000;

  // Value the generator produces after p when running in the given mode.
  function automatic logic [PATTERN_W-1:0] next_pattern(input mode_e mode,
                                                        input logic [PATTERN_W-1:0] p);
    logic [PATTERN_W-1:0] r;
    r = '0;
    case (mode)
      MODE_BINARY: r = p + 8'd1;
      MODE_SCANNER: begin
        // 0x00 and the top end both restart the scan at bit 0.
        if (p == 8'h00 || p == 8'h80) r = 8'h01;
        else if (p < 8'h80)           r = p << 1;
        else                          r = p >> 1;
      end
      MODE_LFSR: begin
        // All-zero is the lock-up state, so it is kicked to 0x01.
        if (p == 8'h00) r = 8'h01;
        else            r = {p[6:0], ^(p & LFSR_TAPS)};
      end
      default: r = (p == 8'h55) ? 8'hAA : 8'h55;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_pattern_monitor_if.sv
// -----------------------------------------------------------------------------
// led_pattern_monitor_if
// Bundles the LED bus, enable and all monitor status outputs.
//   master : drives enable/led_inputs, observes the status outputs
//   slave  : the monitor itself
// -----------------------------------------------------------------------------
interface led_pattern_monitor_if;
  import led_pattern_pkg::*;

  logic                 enable;
  logic [PATTERN_W-1:0] led_inputs;
  logic [1:0]           mode_detected;
  logic                 locked;
  logic                 ambiguous;
  logic                 step_pulse;
  logic                 mismatch_pulse;
  logic [7:0]           period;

  modport master (
    output enable, led_inputs,
    input  mode_detected, locked, ambiguous, step_pulse, mismatch_pulse, period
  );

  modport slave (
    input  enable, led_inputs,
    output mode_detected, locked, ambiguous, step_pulse, mismatch_pulse, period
  );

endinterface

// File: rtl/led_pattern_predictor.sv
// -----------------------------------------------------------------------------
// led_pattern_predictor
// Combinational: compares the newly sampled bus value against the successor
// of the previous value for every pattern mode.
//   prev_q : last accepted bus value
//   in_q   : current sampled bus value
//   match  : bit m set when in_q is mode m's successor of prev_q
// -----------------------------------------------------------------------------
module led_pattern_predictor
  import led_pattern_pkg::*;
(
  input  logic [PATTERN_W-1:0] prev_q,
  input  logic [PATTERN_W-1:0] in_q,
  output logic [NUM_MODES-1:0] match
);

  for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_mode
    localparam logic [1:0] MODE_IDX = 2'(gi);
    assign match[gi] = (in_q == next_pattern(mode_e'(MODE_IDX), prev_q));
  end

endmodule

// File: rtl/led_pattern_monitor.sv
// -----------------------------------------------------------------------------
// led_pattern_monitor
// Samples the LED bus, detects pattern steps, scores each step against all
// generator modes and reports the locked mode and step period.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of led_pattern_monitor_if (enable, led_inputs in;
//           mode_detected, locked, ambiguous, step_pulse, mismatch_pulse,
//           period out)
// -----------------------------------------------------------------------------
module led_pattern_monitor
  import led_pattern_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  led_pattern_monitor_if.slave  bus
);

  localparam logic [3:0] LOCK_VAL    = 4'(LOCK_COUNT);
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

  logic [PATTERN_W-1:0]      in_q_reg, prev_q_reg;
  logic [7:0]                gap_reg, gap_next;
  logic [7:0]                period_reg, period_next;
  logic [NUM_MODES-1:0][3:0] conf_reg, conf_next;
  logic [NUM_MODES-1:0]      match, sat_next;
  logic [1:0]                mode_reg, mode_next;
  logic                      locked_reg, locked_next;
  logic                      ambiguous_reg, ambiguous_next;
  logic                      step_pulse_reg, mismatch_pulse_reg, mismatch_next;
  logic                      step, timeout;

  led_pattern_predictor u_predictor (
    .prev_q (prev_q_reg),
    .in_q   (in_q_reg),
    .match  (match)
  );

  assign step = bus.enable && (in_q_reg != prev_q_reg);

  // Gap/period tracking. A step resets the gap, so it also suppresses any
  // timeout that would otherwise land on the same cycle.
  always_comb begin
    gap_next    = gap_reg;
    period_next = period_reg;
    if (step) begin
      gap_next    = 8'd0;
      period_next = (gap_reg == 8'hFF) ? 8'hFF : gap_reg + 8'd1;
    end else if (gap_reg != 8'hFF) begin
      gap_next = gap_reg + 8'd1;
    end
  end

  // Fires only on the cycle the gap arrives at TIMEOUT, not while it sits there.
  assign timeout = !step && (gap_next == TIMEOUT_VAL) && (gap_reg != TIMEOUT_VAL);

  always_comb begin
    conf_next = conf_reg;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (step) begin
        if (!match[i])                  conf_next[i] = 4'd0;
        else if (conf_reg[i] < LOCK_VAL) conf_next[i] = conf_reg[i] + 4'd1;
        else                            conf_next[i] = LOCK_VAL;
      end else if (timeout) begin
        conf_next[i] = 4'd0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_sat
    assign sat_next[gi] = (conf_next[gi] == LOCK_VAL);
  end

  // Status is decoded from the post-update counters so it moves together
  // with the step that caused it.
  always_comb begin
    locked_next    = (sat_next != '0) && ((sat_next & (sat_next - 1'b1)) == '0);
    ambiguous_next = (sat_next != '0) && !locked_next;
    mode_next      = mode_reg;
    if (locked_next) begin
      for (int i = 0; i < NUM_MODES; i++) begin
        if (sat_next[i]) mode_next = 2'(i);
      end
    end
  end

  assign mismatch_next = step && locked_reg && !match[mode_reg];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_q_reg           <= '0;
      prev_q_reg         <= '0;
      gap_reg            <= '0;
      period_reg         <= '0;
      conf_reg           <= '0;
      mode_reg           <= '0;
      locked_reg         <= 1'b0;
      ambiguous_reg      <= 1'b0;
      step_pulse_reg     <= 1'b0;
      mismatch_pulse_reg <= 1'b0;
    end else if (bus.enable) begin
      in_q_reg           <= bus.led_inputs;
      if (step) prev_q_reg <= in_q_reg;
      gap_reg            <= gap_next;
      period_reg         <= period_next;
      conf_reg           <= conf_next;
      mode_reg           <= mode_next;
      locked_reg         <= locked_next;
      ambiguous_reg      <= ambiguous_next;
      step_pulse_reg     <= step;
      mismatch_pulse_reg <= mismatch_next;
    end else begin
      // Pulses must not reappear when enable returns.
      step_pulse_reg     <= 1'b0;
      mismatch_pulse_reg <= 1'b0;
    end
  end

  assign bus.mode_detected  = mode_reg;
  assign bus.locked         = locked_reg;
  assign bus.ambiguous      = ambiguous_reg;
  assign bus.period         = period_reg;
  assign bus.step_pulse     = step_pulse_reg && bus.enable;
  assign bus.mismatch_pulse = mismatch_pulse_reg && bus.enable;

endmodule

// File: doc/led_pattern_monitor.md
# led_pattern_monitor

Receive-side checker for the LED pattern generator. It samples an 8-bit LED bus, finds each pattern step, and tests every step against the four generator update rules: binary count, scanner, LFSR and alternating. It reports which mode is running, whether it has locked, and the measured step period. It sits on the bench or board side of the generator outputs and is used for self-test and bring-up.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive matching steps needed for a mode to saturate (range 2–15).
- TIMEOUT, 64: sampled cycles without a step before all confidence is cleared (range 2–255).

Ports:
- clock  in  1  system clock; all logic uses the rising edge.
- reset  in  1  asynchronous, active-high reset. Clears every register immediately.
- enable  in  1  when low, every register holds and pulse outputs read 0.
- led_inputs  in  8  LED bus, synchronous to clock.
- mode_detected  out  2  locked mode: 0 binary, 1 scanner, 2 LFSR, 3 alternating.
- locked  out  1  exactly one mode is saturated.
- ambiguous  out  1  more than one mode is saturated.
- step_pulse  out  1  one-cycle pulse per detected step.
- mismatch_pulse  out  1  one-cycle pulse when a step breaks the currently locked mode.
- period  out  8  sampled cycles between the last two steps, saturating at 255.

## Operation
- Sample stage: in_q <= led_inputs. prev_q holds the last accepted value; its reset value is 0x00, matching the generator's reset output.
- Step: in_q != prev_q. On a step, prev_q <= in_q.
- Predicted next value for previous value p:
  - binary: p+1 mod 256.
  - scanner: 0x01 if p is 0x00 or 0x80; p<<1 if p<0x80; otherwise p>>1.
  - LFSR: 0x01 if p==0x00; otherwise {p[6:0], p[7]^p[5]^p[4]^p[3]}.
  - alternating: 0xAA if p==0x55, otherwise 0x55.
- Confidence counters, one per mode, 4 bits wide:
  - On a step, a counter increments (saturating at LOCK_COUNT) if in_q equals that mode's prediction, and clears to 0 otherwise.
  - Several modes may match the same step.
- Decode from the next-state counters:
  - locked = exactly one counter at LOCK_COUNT.
  - ambiguous = two or more counters at LOCK_COUNT.
  - mode_detected = index of the single saturated counter. It holds its last value when locked is 0.
- mismatch_pulse: a step occurs, locked was 1, and the locked mode's prediction failed.
- Gap counter, 8 bits:
  - Increments on each enabled cycle without a step, saturating at 255.
  - On a step: period <= min(gap+1, 255), then gap <= 0.
- Timeout: when gap becomes equal to TIMEOUT, all counters clear and locked/ambiguous fall.
- Step and timeout in the same cycle: the step wins, and no timeout occurs.
- Reset mid-operation: every output goes to 0 at once. The first step after release is judged against prev_q = 0x00.

## Timing
- Reset values: mode_detected=0, locked=0, ambiguous=0, step_pulse=0, mismatch_pulse=0, period=0.
- Latency: a bus value captured at edge N updates all outputs at edge N+1.
- step_pulse and mismatch_pulse last exactly one cycle (the cycle after edge N+1).
- enable low: in_q, prev_q, gap and counters all hold, and both pulses are 0.
- The input is assumed stable for at least 1 cycle per value. A change lasting only 1 cycle still counts as a step.

## Structure
- Shared package led_pattern_pkg holds:
  - mode encodings MODE_BINARY=0, MODE_SCANNER=1, MODE_LFSR=2, MODE_ALT=3;
  - constants PATTERN_W=8, LFSR_TAPS (bits 7,5,4,3);
  - function next_pattern(mode, p), also reused by the generator's reference model.
- Sub-module led_pattern_predictor: purely combinational. Takes prev_q and in_q and returns a 4-bit match vector.

## Test plan
- Reset, then feed 00,01,02,03,04 with each value held 16 cycles. Required: locked=1, mode_detected=0 after 04; period=16.
- Feed 00,55,AA,55,AA. Required: locked=1, mode_detected=3, ambiguous=0.
- Feed 00,01,02,04,08. Required: ambiguous=1, locked=0 (scanner and LFSR both saturated).
  - Then feed 10: locked=1, mode_detected=1.
  - Alternate branch, feeding 11 instead of 10: mode_detected=2.
- Lock on binary at 04, then drive 07. Required: mismatch_pulse for one cycle, locked=0, all counters 0.
- Lock, then hold the bus constant for 64 cycles. Required: locked falls exactly when gap reaches 64.
  - Variant: with enable low for 100 cycles, locked holds.
- Assert reset mid-lock. Required: all outputs 0 with no clock edge.
  - After release, feed 37. Required: step_pulse for one cycle, no lock.
